// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage : ID stage of the MIPS R2000 pipeline (sits right after IF).
//
//   clk, rst                  clock / asynchronous active-high reset
//   pc_in, inst_in            instruction in ID and its PC (inst 0 = nop)
//   wb_we, wb_addr, wb_data   register-file write-back port
//   ex_mem_read, ex_rt        load currently in EX and its destination
//   hold_pc, hold_if          load-use stall request back to IF
//   br, pc_branch             taken beq/bne/j and its target
//   except, epc               illegal opcode / syscall, PC of that instruction
//   id_*                      registered ID/EX pipeline word (id_valid=0 -> bubble)
// ---------------------------------------------------------------------------
module decode_stage #(
   parameter  int NREG   = 32,
   parameter  int DATA_W = 32,
   localparam int AW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [31:0]       inst_in,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_mem_read,
   input  logic [AW-1:0]     ex_rt,
   output logic              hold_pc,
   output logic              hold_if,
   output logic              br,
   output logic [DATA_W-1:0] pc_branch,
   output logic              except,
   output logic [DATA_W-1:0] epc,
   output logic              id_valid,
   output logic [DATA_W-1:0] id_pc,
   output logic [DATA_W-1:0] id_rs_data,
   output logic [DATA_W-1:0] id_rt_data,
   output logic [DATA_W-1:0] id_imm,
   output logic [AW-1:0]     id_rs,
   output logic [AW-1:0]     id_rt,
   output logic [AW-1:0]     id_rd,
   output logic [5:0]        id_opcode,
   output logic [5:0]        id_funct
);

   typedef enum logic {NORMAL = 1'b0, SQUASH = 1'b1} state_t;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [AW-1:0]     rs;
      logic [AW-1:0]     rt;
      logic [AW-1:0]     rd;
      logic [5:0]        opcode;
      logic [5:0]        funct;
   } idex_t;

   state_t                        state_q, state_d;
   logic [NREG-1:0][DATA_W-1:0]   rf_q, rf_d;
   idex_t                         idex_q, idex_d;
   logic [DATA_W-1:0]             epc_q, epc_d;

   // instruction fields
   logic [5:0]        opcode, funct;
   logic [AW-1:0]     rs, rt, rd;
   logic [DATA_W-1:0] imm_sext;
   assign opcode   = inst_in[31:26];
   assign rs       = inst_in[25:21];
   assign rt       = inst_in[20:16];
   assign rd       = inst_in[15:11];
   assign funct    = inst_in[5:0];
   assign imm_sext = {{(DATA_W-16){inst_in[15]}}, inst_in[15:0]};

   // register file: next state, $0 never written
   always_comb begin
      rf_d = rf_q;
      if (wb_we && wb_addr != '0)
         rf_d[wb_addr] = wb_data;
      rf_d[0] = '0;
   end

   // write-first reads so a same-cycle write-back is seen by ID
   logic [DATA_W-1:0] rs_data, rt_data;
   assign rs_data = (rs == '0) ? '0 :
                    (wb_we && wb_addr == rs) ? wb_data : rf_q[rs];
   assign rt_data = (rt == '0) ? '0 :
                    (wb_we && wb_addr == rt) ? wb_data : rf_q[rt];

   // opcode classification
   logic legal, uses_rt, is_j, is_beq, is_bne;
   always_comb begin
      legal   = 1'b0;
      uses_rt = 1'b0;
      case (opcode)
         6'h00: begin
            legal   = (funct != 6'h0C);   // syscall traps
            uses_rt = 1'b1;
         end
         6'h04, 6'h05, 6'h2B: begin
            legal   = 1'b1;
            uses_rt = 1'b1;
         end
         6'h02, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end
   assign is_j   = (opcode == 6'h02);
   assign is_beq = (opcode == 6'h04);
   assign is_bne = (opcode == 6'h05);

   // hazard / branch / exception, in priority order
   logic normal, except_c, stall_c, br_c, ops_eq;
   assign normal   = (state_q == NORMAL);
   assign ops_eq   = (rs_data == rt_data);
   assign except_c = normal && !legal;
   assign stall_c  = normal && legal && ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == rs) || (uses_rt && ex_rt == rt));
   assign br_c     = normal && legal && !stall_c &&
                     (is_j || (is_beq && ops_eq) || (is_bne && !ops_eq));

   logic [DATA_W-1:0] pc_plus4, b_target, j_target;
   assign pc_plus4 = pc_in + DATA_W'(4);
   assign b_target = pc_plus4 + {imm_sext[DATA_W-3:0], 2'b00};
   assign j_target = {pc_plus4[DATA_W-1:DATA_W-4], inst_in[25:0], 2'b00};

   // combinational outputs are held low for the whole of reset
   assign hold_pc   = !rst && stall_c;
   assign hold_if   = !rst && stall_c;
   assign except    = !rst && except_c;
   assign br        = !rst && br_c;
   assign pc_branch = (!rst && br_c) ? (is_j ? j_target : b_target) : '0;

   // next-state logic for FSM, ID/EX word and EPC
   always_comb begin
      state_d = NORMAL;
      if (normal && except_c)
         state_d = SQUASH;

      epc_d = except_c ? pc_in : epc_q;

      // anything that is not a clean NORMAL issue becomes a zeroed bubble
      idex_d = '0;
      if (normal && !except_c && !stall_c) begin
         idex_d.valid   = 1'b1;
         idex_d.pc      = pc_in;
         idex_d.rs_data = rs_data;
         idex_d.rt_data = rt_data;
         idex_d.imm     = imm_sext;
         idex_d.rs      = rs;
         idex_d.rt      = rt;
         idex_d.rd      = rd;
         idex_d.opcode  = opcode;
         idex_d.funct   = funct;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= NORMAL;
         rf_q    <= '0;
         idex_q  <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         rf_q    <= rf_d;
         idex_q  <= idex_d;
         epc_q   <= epc_d;
      end
   end

   assign epc        = epc_q;
   assign id_valid   = idex_q.valid;
   assign id_pc      = idex_q.pc;
   assign id_rs_data = idex_q.rs_data;
   assign id_rt_data = idex_q.rt_data;
   assign id_imm     = idex_q.imm;
   assign id_rs      = idex_q.rs;
   assign id_rt      = idex_q.rt;
   assign id_rd      = idex_q.rd;
   assign id_opcode  = idex_q.opcode;
   assign id_funct   = idex_q.funct;

endmodule
